stack_ctx_ring: RTL and testbench
=================================

// Module: stack_ctx_ring
// PURPOSE
//  Parametrised barrel-threaded data/return stack: CONTEXTS independent stacks
//  rotated through one shared update port, one context per clock, round-robin.
//  Serves the multi-threaded J1 core: the slot on rd each cycle belongs to
//  context ctx. Adds sync reset, fill pattern, per-context depth and sticky
//  overflow/underflow flags.
// PARAMETERS
//  WIDTH     16       data width
//  DEPTH     18       tail entries; capacity = DEPTH+1 (head + tail)
//  CONTEXTS  4        number of contexts (>=1); CB = max(1,$clog2(CONTEXTS))
//  FILL      16'h55aa value shifted into tail bottom on pop; reset contents
//  DB        $clog2(DEPTH+2)  width of depth counter
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  ctx        out  CB     context owning this cycle's slot
//  rd         out  WIDTH  head (TOS) of context ctx
//  we         in   1      write wd into head of context ctx
//  delta      in   2      00 none, 01 push, 11 pop, 10 none (reserved)
//  wd         in   WIDTH  write data
//  err_clr    in   1      clear overflow/underflow of context ctx
//  depth      out  DB     entry count of context ctx, 0..DEPTH+1
//  overflow   out  1      sticky: context ctx pushed while full
//  underflow  out  1      sticky: context ctx popped while empty
// BEHAVIOUR
//  - Reset (while high, any cycle): ctx=0; every head and tail entry = FILL;
//    every depth=0, flags=0. First cycle after reset: rd=FILL, depth=0, ctx=0.
//  - ctx advances by 1 each clock, wraps CONTEXTS-1 -> 0; not gated by inputs.
//  - Inputs in a cycle apply only to context ctx; other contexts hold.
//  - move = delta[0]. Tail index 0 = entry just below head.
//  - push (01): tail <= {tail[DEPTH-2:0], head}; bottom entry discarded;
//    head <= we ? wd : tail[0].
//  - pop (11): tail <= {FILL, tail[DEPTH-1:1]} (FILL enters bottom);
//    head <= we ? wd : tail[0].
//  - no move (00/10): head <= wd if we, else hold; tail holds.
//  - Latency: update made in ctx=c slot is visible on rd/depth/flags at the
//    next slot of c, i.e. exactly CONTEXTS cycles later. CONTEXTS=1: next
//    cycle (plain stack).
//  - rd, depth, overflow, underflow are combinational from the stored state
//    of context ctx; they never reflect same-cycle inputs.
//  - depth: push +1, pop -1, saturating. Push at depth=DEPTH+1: data shifts
//    as above (oldest lost), depth stays DEPTH+1, overflow<=1. Pop at
//    depth=0: data shifts as above, depth stays 0, underflow<=1.
//  - err_clr clears both flags of ctx; same-cycle new error wins (flag=1).
//  - delta=10 with we: behaves as 00 with we (TOS replace); no depth change.
//  - Reset mid-operation discards all in-flight updates; no partial state.
// TESTING
//  1 Reset, CONTEXTS=4: cycles 0..3 show ctx 0,1,2,3, rd=16'h55aa, depth=0,
//    flags 0; cycle 4 ctx=0 again.
//  2 Ctx0 push wd=16'h1234 (we=1,delta=01) at cycle 0 -> cycle 4 ctx=0
//    rd=16'h1234, depth=1; ctx 1..3 still rd=16'h55aa, depth=0.
//  3 Ctx2 push 1,2,3 over three of its slots, then pop x3 (we=0) -> rd
//    sequence 3,2,1,16'h55aa; depth 3,2,1,0; underflow stays 0; 4th pop ->
//    underflow=1, depth=0.
//  4 Ctx1 push DEPTH+2 values 1..20 -> depth=19 sat, overflow=1; pop 19 times
//    -> rd 20..2, then 16'h55aa (value 1 lost); err_clr slot -> overflow=0.
//  5 we=1, delta=00, wd=16'hbeef on ctx3 -> rd=16'hbeef next ctx3 slot, depth
//    unchanged; delta=10 same result.
//  6 Reset asserted 1 cycle mid-sequence of test 4 -> all contexts FILL,
//    depth 0, flags 0, ctx=0 next cycle; repeat tests 1-5 with CONTEXTS=1
//    (1-cycle latency).

Source files
------------

// File: rtl/stack_ctx_ring.sv
// -----------------------------------------------------------------------------
// stack_ctx_ring
//
// Barrel-threaded data/return stack. CONTEXTS independent stacks share one
// update port; the port is handed to one context per clock in fixed
// round-robin order. The context owning the current slot is shown on ctx, and
// rd/depth/overflow/underflow show that context's stored state. Inputs applied
// in a slot update only that context, so a context sees its own update at its
// next slot, CONTEXTS cycles later (next cycle when CONTEXTS = 1).
//
// Each stack is a head register (TOS, shown on rd) plus DEPTH tail entries;
// tail index 0 is the entry just below the head. Capacity is DEPTH+1.
// DEPTH must be at least 2.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      synchronous, active-high; fills all stacks with FILL
//   ctx        out  CB     context owning this cycle's slot
//   rd         out  WIDTH  head (TOS) of context ctx
//   we         in   1      write wd into head of context ctx
//   delta      in   2      00 none, 01 push, 11 pop, 10 none (reserved)
//   wd         in   WIDTH  write data
//   err_clr    in   1      clear overflow/underflow of context ctx
//   depth      out  DB     entry count of context ctx, 0..DEPTH+1
//   overflow   out  1      sticky: context ctx pushed while full
//   underflow  out  1      sticky: context ctx popped while empty
// -----------------------------------------------------------------------------
module stack_ctx_ring #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 18,
    parameter int               CONTEXTS = 4,
    parameter logic [WIDTH-1:0] FILL     = 16'h55aa,
    parameter int               CB       = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1,
    parameter int               DB       = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CB-1:0]    ctx,
    output logic [WIDTH-1:0] rd,
    input  logic             we,
    input  logic [1:0]       delta,
    input  logic [WIDTH-1:0] wd,
    input  logic             err_clr,
    output logic [DB-1:0]    depth,
    output logic             overflow,
    output logic             underflow
);

    // Storage is sized to the full range of the ctx counter so every index
    // value addresses a real entry; slots >= CONTEXTS are simply never visited.
    localparam int            NSLOT = 1 << CB;
    localparam logic [DB-1:0] FULL  = DB'(DEPTH + 1);
    localparam logic [CB-1:0] LAST  = CB'(CONTEXTS - 1);

    logic [CB-1:0]                 r_ctx;
    logic [WIDTH-1:0]              r_head  [NSLOT];
    logic [DEPTH-1:0][WIDTH-1:0]   r_tail  [NSLOT];
    logic [DB-1:0]                 r_depth [NSLOT];
    logic                          r_ovf   [NSLOT];
    logic                          r_unf   [NSLOT];

    logic                          w_push;
    logic                          w_pop;
    logic [WIDTH-1:0]              w_head_cur;
    logic [DEPTH-1:0][WIDTH-1:0]   w_tail_cur;
    logic [DB-1:0]                 w_depth_cur;
    logic                          w_ovf_hit;
    logic                          w_unf_hit;
    logic [WIDTH-1:0]              w_head_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]   w_tail_nxt;
    logic [DB-1:0]                 w_depth_nxt;
    logic                          w_ovf_nxt;
    logic                          w_unf_nxt;
    logic [CB-1:0]                 w_ctx_nxt;

    // Next state of the context that owns the current slot.
    always_comb begin
        w_push      = (delta == 2'b01);
        w_pop       = (delta == 2'b11);
        w_head_cur  = r_head[r_ctx];
        w_tail_cur  = r_tail[r_ctx];
        w_depth_cur = r_depth[r_ctx];

        w_tail_nxt  = w_tail_cur;
        w_head_nxt  = w_head_cur;
        w_depth_nxt = w_depth_cur;

        // Data always shifts, even when the depth counter saturates: a push
        // at full capacity drops the bottom entry, a pop at empty pulls FILL.
        if (w_push) begin
            w_tail_nxt = {w_tail_cur[DEPTH-2:0], w_head_cur};
        end else if (w_pop) begin
            w_tail_nxt = {FILL, w_tail_cur[DEPTH-1:1]};
        end

        // Any move brings tail[0] up unless the head is written this slot.
        if (we) begin
            w_head_nxt = wd;
        end else if (delta[0]) begin
            w_head_nxt = w_tail_cur[0];
        end

        w_ovf_hit = w_push && (w_depth_cur == FULL);
        w_unf_hit = w_pop  && (w_depth_cur == '0);

        if (w_push && !w_ovf_hit) begin
            w_depth_nxt = w_depth_cur + DB'(1);
        end else if (w_pop && !w_unf_hit) begin
            w_depth_nxt = w_depth_cur - DB'(1);
        end

        // A new error in the same slot as err_clr leaves the flag set.
        w_ovf_nxt = (r_ovf[r_ctx] && !err_clr) || w_ovf_hit;
        w_unf_nxt = (r_unf[r_ctx] && !err_clr) || w_unf_hit;

        w_ctx_nxt = (r_ctx == LAST) ? '0 : r_ctx + CB'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctx <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                r_head[i]  <= FILL;
                r_tail[i]  <= {DEPTH{FILL}};
                r_depth[i] <= '0;
                r_ovf[i]   <= 1'b0;
                r_unf[i]   <= 1'b0;
            end
        end else begin
            r_ctx          <= w_ctx_nxt;
            r_head[r_ctx]  <= w_head_nxt;
            r_tail[r_ctx]  <= w_tail_nxt;
            r_depth[r_ctx] <= w_depth_nxt;
            r_ovf[r_ctx]   <= w_ovf_nxt;
            r_unf[r_ctx]   <= w_unf_nxt;
        end
    end

    // Outputs come from stored state only, never from this cycle's inputs.
    assign ctx       = r_ctx;
    assign rd        = r_head[r_ctx];
    assign depth     = r_depth[r_ctx];
    assign overflow  = r_ovf[r_ctx];
    assign underflow = r_unf[r_ctx];

endmodule

// File: tb/tb_stack_ctx_ring.sv
// -----------------------------------------------------------------------------
// tb_stack_ctx_ring
//
// Bench for stack_ctx_ring. Two instances run side by side: u_dut4 with four
// contexts and u_dut1 with a single context. A list-based stack model per
// context (index 0 = top of stack) predicts every output; a compare process
// checks both instances against it on every falling edge. Directed sequences
// add literal expectations, then a randomized phase with occasional resets.
// -----------------------------------------------------------------------------
module tb_stack_ctx_ring;

    localparam int          D    = 18;
    localparam int          CAP  = D + 1;
    localparam logic [15:0] FILL = 16'h55aa;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]  ctx4;
    logic [15:0] rd4;
    logic        we4    = 1'b0;
    logic [1:0]  delta4 = 2'b00;
    logic [15:0] wd4    = '0;
    logic        clr4   = 1'b0;
    logic [4:0]  dep4;
    logic        ovf4, unf4;

    logic [0:0]  ctx1;
    logic [15:0] rd1;
    logic        we1    = 1'b0;
    logic [1:0]  delta1 = 2'b00;
    logic [15:0] wd1    = '0;
    logic        clr1   = 1'b0;
    logic [4:0]  dep1;
    logic        ovf1, unf1;

    stack_ctx_ring #(.WIDTH(16), .DEPTH(D), .CONTEXTS(4), .FILL(FILL)) u_dut4 (
        .clk(clk), .reset(reset), .ctx(ctx4), .rd(rd4), .we(we4), .delta(delta4),
        .wd(wd4), .err_clr(clr4), .depth(dep4), .overflow(ovf4), .underflow(unf4)
    );

    stack_ctx_ring #(.WIDTH(16), .DEPTH(D), .CONTEXTS(1), .FILL(FILL)) u_dut1 (
        .clk(clk), .reset(reset), .ctx(ctx1), .rd(rd1), .we(we1), .delta(delta1),
        .wd(wd1), .err_clr(clr1), .depth(dep1), .overflow(ovf1), .underflow(unf1)
    );

    // ---------------- scoreboard counters ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m = 0 : four-context instance, m = 1 : single-context instance.
    logic [15:0] m_stk [2][4][CAP];
    int          m_dep [2][4];
    logic        m_ovf [2][4];
    logic        m_unf [2][4];
    int          m_ctx4 = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < CAP; i++) m_stk[m][c][i] = FILL;
                m_dep[m][c] = 0;
                m_ovf[m][c] = 1'b0;
                m_unf[m][c] = 1'b0;
            end
        end
        m_ctx4 = 0;
    endtask

    task automatic model_step(input int m, input int c, input logic we, input logic [1:0] dl,
                              input logic [15:0] wd, input logic clr);
        logic [15:0] s [CAP];
        logic [15:0] n [CAP];
        logic        ovf_hit = 1'b0;
        logic        unf_hit = 1'b0;
        for (int i = 0; i < CAP; i++) s[i] = m_stk[m][c][i];
        n = s;
        if (dl == 2'b01) begin
            // push old top down one place; bottom element falls off
            for (int i = 1; i < CAP; i++) n[i] = s[i-1];
            n[0] = s[1];
            if (m_dep[m][c] == CAP) ovf_hit = 1'b1;
            else m_dep[m][c]++;
        end else if (dl == 2'b11) begin
            // drop top; everything rises; FILL appears at bottom
            for (int i = 0; i < CAP - 1; i++) n[i] = s[i+1];
            n[CAP-1] = FILL;
            if (m_dep[m][c] == 0) unf_hit = 1'b1;
            else m_dep[m][c]--;
        end
        if (we) n[0] = wd;
        for (int i = 0; i < CAP; i++) m_stk[m][c][i] = n[i];
        if (clr) begin
            m_ovf[m][c] = 1'b0;
            m_unf[m][c] = 1'b0;
        end
        if (ovf_hit) m_ovf[m][c] = 1'b1;
        if (unf_hit) m_unf[m][c] = 1'b1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            model_step(0, m_ctx4, we4, delta4, wd4, clr4);
            m_ctx4 = (m_ctx4 + 1) % 4;
            model_step(1, 0, we1, delta1, wd1, clr1);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctx4",  ctx4, m_ctx4);
            chk("rd4",   rd4,  m_stk[0][m_ctx4][0]);
            chk("dep4",  dep4, m_dep[0][m_ctx4]);
            chk("ovf4",  ovf4, m_ovf[0][m_ctx4]);
            chk("unf4",  unf4, m_unf[0][m_ctx4]);
            chk("ctx1",  ctx1, 0);
            chk("rd1",   rd1,  m_stk[1][0][0]);
            chk("dep1",  dep1, m_dep[1][0]);
            chk("ovf1",  ovf1, m_ovf[1][0]);
            chk("unf1",  unf1, m_unf[1][0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle4();
        we4 = 1'b0; delta4 = 2'b00; wd4 = '0; clr4 = 1'b0;
    endtask

    task automatic idle1();
        we1 = 1'b0; delta1 = 2'b00; wd1 = '0; clr1 = 1'b0;
    endtask

    // Wait for context c's slot on the four-context instance, capture its
    // outputs there (state before this slot's update), then drive the inputs.
    task automatic slot4(input int c, input logic w, input logic [1:0] dl, input logic [15:0] v,
                         input logic clr, output logic [15:0] o_rd, output int o_dep,
                         output logic o_ovf, output logic o_unf);
        logic found = 1'b0;
        o_rd = 'x; o_dep = -1; o_ovf = 1'bx; o_unf = 1'bx;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk); #1;
            if (m_ctx4 == c) begin
                found = 1'b1;
                o_rd = rd4; o_dep = int'(dep4); o_ovf = ovf4; o_unf = unf4;
                we4 = w; delta4 = dl; wd4 = v; clr4 = clr;
            end else begin
                idle4();
            end
        end
        chk("slot4_reached", found, 1);
    endtask

    task automatic slot1(input logic w, input logic [1:0] dl, input logic [15:0] v, input logic clr,
                         output logic [15:0] o_rd, output int o_dep,
                         output logic o_ovf, output logic o_unf);
        @(negedge clk); #1;
        o_rd = rd1; o_dep = int'(dep1); o_ovf = ovf1; o_unf = unf1;
        we1 = w; delta1 = dl; wd1 = v; clr1 = clr;
    endtask

    // One-cycle reset pulse, then check every context of both instances.
    task automatic pulse_reset();
        @(negedge clk); #1;
        idle4(); idle1();
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            chk("rst_ctx4", ctx4, i);
            chk("rst_rd4",  rd4,  FILL);
            chk("rst_dep4", dep4, 0);
            chk("rst_flg4", {ovf4, unf4}, 0);
            chk("rst_rd1",  rd1,  FILL);
            chk("rst_dep1", dep1, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] c_rd;
    int          c_dep;
    logic        c_ovf, c_unf;

    initial begin
        // reset held from time 0 through two rising edges
        @(negedge clk); @(negedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Test 1: ctx walks 0,1,2,3,0 with FILL and empty stacks
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            chk("t1_ctx", ctx4, i % 4);
            chk("t1_rd",  rd4,  FILL);
            chk("t1_dep", dep4, 0);
            chk("t1_flg", {ovf4, unf4}, 0);
        end

        // Test 2: ctx0 push 1234; others untouched
        slot4(0, 1'b1, 2'b01, 16'h1234, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        for (int c = 1; c < 4; c++) begin
            slot4(c, 1'b0, 2'b00, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
            chk("t2_other_rd", c_rd, FILL);
            chk("t2_other_dep", c_dep, 0);
        end
        slot4(0, 1'b0, 2'b00, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("t2_rd", c_rd, 16'h1234);
        chk("t2_dep", c_dep, 1);

        // Test 3: ctx2 push 1,2,3, pop x4
        for (int v = 1; v <= 3; v++)
            slot4(2, 1'b1, 2'b01, 16'(v), 1'b0, c_rd, c_dep, c_ovf, c_unf);
        for (int k = 0; k < 4; k++) begin
            slot4(2, 1'b0, 2'b11, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
            chk("t3_rd",  c_rd,  (k < 3) ? 16'(3 - k) : FILL);
            chk("t3_dep", c_dep, 3 - k);
            chk("t3_unf", c_unf, 0);
        end
        slot4(2, 1'b0, 2'b00, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("t3_unf_set", c_unf, 1);
        chk("t3_dep_sat", c_dep, 0);

        // Test 4: ctx1 push 1..20, pop 19, clear overflow
        for (int v = 1; v <= D + 2; v++)
            slot4(1, 1'b1, 2'b01, 16'(v), 1'b0, c_rd, c_dep, c_ovf, c_unf);
        for (int k = 0; k < CAP; k++) begin
            slot4(1, 1'b0, 2'b11, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
            chk("t4_rd",  c_rd,  16'(20 - k));
            chk("t4_dep", c_dep, 19 - k);
            chk("t4_ovf", c_ovf, 1);
        end
        slot4(1, 1'b0, 2'b00, 16'h0, 1'b1, c_rd, c_dep, c_ovf, c_unf);
        chk("t4_rd_empty", c_rd, FILL);
        chk("t4_dep_empty", c_dep, 0);
        slot4(1, 1'b0, 2'b00, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("t4_ovf_clr", c_ovf, 0);

        // Test 5: ctx3 TOS replace with delta 00 and 10
        slot4(3, 1'b1, 2'b01, 16'h0007, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        slot4(3, 1'b1, 2'b00, 16'hbeef, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        slot4(3, 1'b1, 2'b10, 16'hcafe, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("t5_rd00", c_rd, 16'hbeef);
        chk("t5_dep00", c_dep, 1);
        slot4(3, 1'b0, 2'b00, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("t5_rd10", c_rd, 16'hcafe);
        chk("t5_dep10", c_dep, 1);

        // Test 6: reset in the middle of a push sequence
        for (int v = 1; v <= 6; v++)
            slot4(1, 1'b1, 2'b01, 16'(v), 1'b0, c_rd, c_dep, c_ovf, c_unf);
        pulse_reset();

        // Single-context instance: every cycle is its own slot
        slot1(1'b1, 2'b01, 16'h1234, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        slot1(1'b1, 2'b01, 16'h0001, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("c1_rd", c_rd, 16'h1234);
        chk("c1_dep", c_dep, 1);
        slot1(1'b1, 2'b00, 16'hbeef, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        slot1(1'b1, 2'b10, 16'hcafe, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("c1_rd00", c_rd, 16'hbeef);
        chk("c1_dep00", c_dep, 2);
        for (int k = 0; k < 3; k++) begin
            slot1(1'b0, 2'b11, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
            chk("c1_pop_rd", c_rd, (k == 0) ? 16'hcafe : ((k == 1) ? 16'h1234 : FILL));
            chk("c1_pop_dep", c_dep, 2 - k);
        end
        slot1(1'b0, 2'b00, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("c1_unf", c_unf, 1);
        for (int v = 1; v <= D + 2; v++)
            slot1(1'b1, 2'b01, 16'(v), 1'b0, c_rd, c_dep, c_ovf, c_unf);
        // same-slot clear and new error: flag must stay set
        slot1(1'b0, 2'b01, 16'h0, 1'b1, c_rd, c_dep, c_ovf, c_unf);
        chk("c1_full_rd", c_rd, 16'd20);
        chk("c1_full_ovf", c_ovf, 1);
        slot1(1'b0, 2'b00, 16'h0, 1'b1, c_rd, c_dep, c_ovf, c_unf);
        chk("c1_clr_win", c_ovf, 1);
        chk("c1_unf_clr", c_unf, 0);
        slot1(1'b0, 2'b00, 16'h0, 1'b0, c_rd, c_dep, c_ovf, c_unf);
        chk("c1_ovf_clr", c_ovf, 0);
        chk("c1_dep_sat", c_dep, CAP);
        pulse_reset();

        // Randomized phase; push/pop bias rotates so both limits get reached
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int ph;
            int r;
            @(negedge clk); #1;
            ph = (cyc / 120) % 3;
            r = $urandom_range(0, 9);
            we4    = 1'($urandom_range(0, 1));
            wd4    = 16'($urandom);
            clr4   = ($urandom_range(0, 15) == 0);
            delta4 = (r < ((ph == 0) ? 7 : ((ph == 1) ? 2 : 4))) ? 2'b01 :
                     (r < 8) ? 2'b11 : 2'($urandom_range(0, 1) << 1);
            r = $urandom_range(0, 9);
            we1    = 1'($urandom_range(0, 1));
            wd1    = 16'($urandom);
            clr1   = ($urandom_range(0, 15) == 0);
            delta1 = (r < ((ph == 0) ? 7 : ((ph == 1) ? 2 : 4))) ? 2'b01 :
                     (r < 8) ? 2'b11 : 2'($urandom_range(0, 1) << 1);
            reset  = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk); #1;
        reset = 1'b0;
        idle4(); idle1();
        repeat (8) @(negedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
